uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Receive-side UART deframer for the SoC's UART peripheral. Sits directly downstream of the io_uart_rx pad.
- Converts the serial 8-data-bit, even-parity, 1-stop-bit stream into a valid/ready byte stream with per-byte error flags.
- Feeds the APB-mapped UART register/FIFO logic.
- Must sustain 16 Mbaud from a 48 MHz clock, i.e. 3 clocks per bit.

Parameters:
- DIV_WIDTH, 16, width of the clocks-per-bit-minus-1 divisor input.
- SYNC_STAGES, 2, number of rx synchronizer flops (minimum 2).

Ports:
- clk  in  1  block clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle level is 1.
- divisor  in  DIV_WIDTH  clocks per bit minus 1; values below 2 are treated as 2.
- parity_en  in  1  1 = expect an even-parity bit after data; 0 = no parity bit.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte; transfer happens when out_valid && out_ready.
- out_data  out  8  received byte, LSB received first.
- out_parity_err  out  1  parity mismatch for the byte on out_data.
- out_frame_err  out  1  stop bit sampled 0 for the byte on out_data.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the output was still full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: out_valid=0, out_data=0, both error flags=0, overrun=0, busy=0, FSM=IDLE. The synchronizer flops reset to 1.
- Reset mid-frame aborts the frame with no output and no error flags.
- rx passes through SYNC_STAGES flops, giving rx_s. All decisions use rx_s.
- Falling edge = previous rx_s is 1 and current rx_s is 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - On a falling edge, latch div_q = max(divisor, 2) and load the bit counter with div_q>>1.
  - Go to START.
  - div_q stays frozen for the whole frame; divisor changes mid-frame have no effect.
- Counter rules:
  - The counter decrements each clock. The sample point is counter==0.
  - At each sample point the counter reloads div_q, giving div_q+1 clocks per bit.
- START, at sample: rx_s=1 means a glitch; return to IDLE with no output and no flags. rx_s=0 goes to DATA with bit index 0.
- DATA:
  - At each sample, shift rx_s into bit 7 of the shift register (LSB-first assembly) and increment the index.
  - After bit 7, go to PARITY if parity_en, else STOP.
  - parity_en is sampled at the start detection, together with divisor.
- PARITY, at sample: par_err = rx_s XOR (XOR of data bits). Go to STOP.
- STOP, at sample: frm_err = ~rx_s. Complete the byte:
  - If out_valid && !out_ready this cycle: overrun=1 for one cycle; the new byte is discarded; out_data and flags keep the old byte.
  - Otherwise, on the next edge: out_valid=1; out_data, out_parity_err and out_frame_err are loaded.
  - Simultaneous completion and consumer handshake is not an overrun; the new byte replaces the old one.
  - Latency: out_valid rises on the clock after the stop-bit sample point.
  - Next state: WAIT_HIGH if frm_err, else IDLE.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break (line held low) produces exactly one frame-error byte.
- From IDLE, a falling edge may be detected on the cycle immediately after the stop sample. Back-to-back frames are supported.
- out_valid clears on the handshake unless a new byte is loaded in that same cycle.
- Output data is stable while out_valid && !out_ready.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - constant UART_DATA_BITS=8;
  - constant UART_MIN_DIV=2;
  - struct uart_rx_byte_t {data, parity_err, frame_err}.
- One sub-module: uart_sync_filter (SYNC_STAGES synchronizer plus falling-edge detect). Reused by the TX loopback checker.

Test Plan:
- Clean byte: divisor=2, parity_en=1, send 0xA5 with parity bit 0, out_ready=1.
  -> One out_valid pulse, out_data=0xA5, both error flags 0, no overrun.
- Bad parity: send 0x3C with parity bit 1.
  -> out_data=0x3C, out_parity_err=1, out_frame_err=0.
- Break: send 0x00 framing, then hold rx low for 3 bit times (9 clocks), then release.
  -> Exactly one byte: 0x00 with out_frame_err=1. No further out_valid until a new start bit after rx returns high.
- Glitch: rx low for 1 clock with divisor=7.
  -> START rejects it, FSM returns to IDLE, out_valid stays 0.
- Overrun: out_ready=0, send 0x11 then 0x22 back-to-back.
  -> overrun pulses once, out_data remains 0x11. Then out_ready=1 -> one transfer of 0x11.
- Reset mid-frame: assert reset during DATA bit 4 of 0xF0.
  -> All outputs 0, FSM IDLE. A following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART receive path
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_MIN_DIV   = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        logic                      parity_err;
        logic                      frame_err;
    } uart_rx_byte_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_filter
// Purpose  : Multi-flop synchronizer for an async serial line plus
//            falling-edge detection on the synchronized level
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_filter
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain and previous-level flop; both idle high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rx_s = r_sync[SYNC_STAGES-1];
    assign fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : UART receive deframer (8 data bits, optional even parity,
//            1 stop bit) producing a valid/ready byte stream with error flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);

    logic                      w_rx_s;
    logic                      w_fall;
    logic [DIV_WIDTH-1:0]      w_div_clamped;

    rx_state_t                 r_state, w_state_n;
    logic [DIV_WIDTH-1:0]      r_cnt, w_cnt_n;
    logic [DIV_WIDTH-1:0]      r_div, w_div_n;
    logic [IDX_W-1:0]          r_idx, w_idx_n;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_n;
    logic                      r_par_en, w_par_en_n;
    logic                      r_par_err, w_par_err_n;
    uart_rx_byte_t             r_out, w_out_n;
    logic                      r_valid, w_valid_n;
    logic                      r_overrun, w_overrun_n;
    logic                      w_sample;
    logic                      w_frm_err;

    uart_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    assign w_div_clamped = (divisor < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : divisor;

    // Next-state, bit timing, shift assembly and output-handshake logic
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_div_n     = r_div;
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_par_en_n  = r_par_en;
        w_par_err_n = r_par_err;
        w_out_n     = r_out;
        w_valid_n   = r_valid;
        w_overrun_n = 1'b0;
        w_frm_err   = 1'b0;
        w_sample    = (r_cnt == '0);

        // Bit-timing counter runs only while a frame is being sampled
        if (r_state inside {START, DATA, PARITY, STOP}) begin
            w_cnt_n = w_sample ? r_div : (r_cnt - DIV_WIDTH'(1));
        end

        // Consumer handshake frees the output register
        if (r_valid && out_ready) begin
            w_valid_n = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    // Frame settings are frozen here for the whole frame
                    w_div_n     = w_div_clamped;
                    w_cnt_n     = w_div_clamped >> 1;
                    w_par_en_n  = parity_en;
                    w_par_err_n = 1'b0;
                    w_state_n   = START;
                end
            end
            START: begin
                if (w_sample) begin
                    if (w_rx_s) begin
                        w_state_n = IDLE;
                    end else begin
                        w_state_n = DATA;
                        w_idx_n   = '0;
                    end
                end
            end
            DATA: begin
                if (w_sample) begin
                    w_shift_n = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_idx_n   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                        w_state_n = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_sample) begin
                    w_par_err_n = w_rx_s ^ (^r_shift);
                    w_state_n   = STOP;
                end
            end
            STOP: begin
                if (w_sample) begin
                    w_frm_err = ~w_rx_s;
                    w_state_n = w_rx_s ? IDLE : WAIT_HIGH;
                    // A byte still held without handshake wins; the new one is dropped
                    if (r_valid && !out_ready) begin
                        w_overrun_n = 1'b1;
                    end else begin
                        w_valid_n          = 1'b1;
                        w_out_n.data       = r_shift;
                        w_out_n.parity_err = r_par_err;
                        w_out_n.frame_err  = w_frm_err;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_err <= 1'b0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_div     <= w_div_n;
            r_idx     <= w_idx_n;
            r_shift   <= w_shift_n;
            r_par_en  <= w_par_en_n;
            r_par_err <= w_par_err_n;
            r_out     <= w_out_n;
            r_valid   <= w_valid_n;
            r_overrun <= w_overrun_n;
        end
    end

    assign out_valid      = r_valid;
    assign out_data       = r_out.data;
    assign out_parity_err = r_out.parity_err;
    assign out_frame_err  = r_out.frame_err;
    assign overrun        = r_overrun;
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deframer
// Purpose  : Self-checking bench for uart_rx_deframer
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deframer;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        int         div;
        logic       pen;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic [7:0] e_data;
        logic       e_pe;
        logic       e_fe;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] divisor = 16'd2;
    logic        parity_en = 1'b1;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_parity_err;
    logic        out_frame_err;
    logic        overrun;
    logic        busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_mode = 1;
    rec_t got [256];
    int   got_n = 0;
    int   ovr_cnt = 0;
    int   rd = 0;

    uart_rx_deframer #(
        .DIV_WIDTH   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .divisor        (divisor),
        .parity_en      (parity_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Consumer: held low, held high, or randomly throttled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Record every accepted byte and every overrun pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready && got_n < 256) begin
                got[got_n] <= '{out_data, out_parity_err, out_frame_err};
                got_n      <= got_n + 1;
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        tick(n);
    endtask

    function automatic int cpb_of(input int d);
        return ((d < 2) ? 2 : d) + 1;
    endfunction

    // Parity bit that makes the count of ones even
    function automatic logic even_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic send_frame(input int d, input logic pen, input logic [7:0] data,
                              input logic pbit, input logic stop, input bit scramble);
        int cpb;
        cpb       = cpb_of(d);
        divisor   = 16'(d);
        parity_en = pen;
        drive_bit(1'b0, cpb);
        if (scramble) begin
            divisor   = 16'($urandom_range(0, 30));
            parity_en = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) drive_bit(data[i], cpb);
        if (pen) drive_bit(pbit, cpb);
        drive_bit(stop, cpb);
    endtask

    task automatic wait_got(input string name, input int need, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_n - rd >= need) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok && (got_n - rd >= need)) ok = 1'b1;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: actual=%0d bytes required=%0d", name, got_n - rd, need);
        end
    endtask

    task automatic check_next(input string name, input logic [7:0] ed, input logic epe, input logic efe);
        rec_t g;
        g = got[rd];
        rd++;
        chk({name, ".data"}, 32'(g.data), 32'(ed));
        chk({name, ".perr"}, 32'(g.pe), 32'(epe));
        chk({name, ".ferr"}, 32'(g.fe), 32'(efe));
    endtask

    initial begin
        vec_t tbl [9];
        rec_t exp_q [$];
        rec_t e;
        bit   ok;
        int   ov0;
        int   d;
        int   gap;
        logic pen;
        logic [7:0] data;
        logic good;
        logic pbit;
        logic stop;

        tbl[0] = '{2, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{2, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[2] = '{2, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{0, 1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[4] = '{1, 1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[5] = '{5, 1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        tbl[6] = '{2, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
        tbl[7] = '{3, 1'b1, 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
        tbl[8] = '{7, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

        // Reset state
        tick(4);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.data", 32'(out_data), 0);
        chk("rst.perr", 32'(out_parity_err), 0);
        chk("rst.ferr", 32'(out_frame_err), 0);
        chk("rst.overrun", 32'(overrun), 0);
        chk("rst.busy", 32'(busy), 0);
        tick(2);

        // Table-driven frames
        ov0 = ovr_cnt;
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].div, tbl[i].pen, tbl[i].data, tbl[i].pbit, tbl[i].stop, 1'b0);
            rx = 1'b1;
            tick(2 * cpb_of(tbl[i].div));
            wait_got($sformatf("vec%0d", i), 1, 200, ok);
            if (ok) check_next($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_pe, tbl[i].e_fe);
        end
        chk("vec.extra", 32'(got_n - rd), 0);
        chk("vec.overrun", 32'(ovr_cnt - ov0), 0);

        // Break: stop bit low then line held low, one byte only
        send_frame(2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 9);
        rx = 1'b1;
        wait_got("break", 1, 100, ok);
        if (ok) check_next("break", 8'h00, 1'b0, 1'b1);
        tick(30);
        chk("break.extra", 32'(got_n - rd), 0);
        chk("break.busy", 32'(busy), 0);

        // Glitch: single low clock rejected by START
        divisor = 16'd7;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(3);
        @(negedge clk);
        chk("glitch.busy_during", 32'(busy), 1);
        tick(20);
        chk("glitch.busy_after", 32'(busy), 0);
        chk("glitch.valid", 32'(out_valid), 0);
        chk("glitch.bytes", 32'(got_n - rd), 0);

        // Overrun: two back-to-back bytes with the consumer stalled
        ready_mode = 0;
        tick(2);
        ov0 = ovr_cnt;
        send_frame(2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(2, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        tick(20);
        chk("ovr.pulses", 32'(ovr_cnt - ov0), 1);
        chk("ovr.valid", 32'(out_valid), 1);
        chk("ovr.held_data", 32'(out_data), 32'h11);
        chk("ovr.no_xfer", 32'(got_n - rd), 0);
        ready_mode = 1;
        tick(6);
        chk("ovr.one_xfer", 32'(got_n - rd), 1);
        if (got_n > rd) check_next("ovr", 8'h11, 1'b0, 1'b0);
        chk("ovr.valid_clr", 32'(out_valid), 0);

        // Reset mid-frame with a byte pending
        ready_mode = 0;
        tick(2);
        send_frame(2, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        tick(10);
        chk("rmid.pending", 32'(out_valid), 1);
        divisor = 16'd2;
        parity_en = 1'b1;
        drive_bit(1'b0, 3);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 3);
        rx = 1'b1;
        tick(1);
        chk("rmid.busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rmid.valid", 32'(out_valid), 0);
        chk("rmid.data", 32'(out_data), 0);
        chk("rmid.ferr", 32'(out_frame_err), 0);
        chk("rmid.overrun", 32'(overrun), 0);
        chk("rmid.busy", 32'(busy), 0);
        ready_mode = 1;
        tick(10);
        chk("rmid.no_xfer", 32'(got_n - rd), 0);
        send_frame(2, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        wait_got("rmid.after", 1, 100, ok);
        if (ok) check_next("rmid.after", 8'h5A, 1'b0, 1'b0);

        // Randomized frames against the reference model
        ready_mode = 2;
        tick(5);
        ov0 = ovr_cnt;
        for (int n = 0; n < 40; n++) begin
            d    = $urandom_range(0, 9);
            pen  = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            good = even_par(data);
            pbit = ($urandom_range(0, 3) == 0) ? ~good : good;
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, pen, data, pbit, stop, 1'b1);
            e.data = data;
            e.pe   = pen && (pbit != good);
            e.fe   = !stop;
            exp_q.push_back(e);
            gap = $urandom_range(stop ? 0 : 1, 2 * cpb_of(d));
            rx = 1'b1;
            if (gap > 0) tick(gap);
        end
        rx = 1'b1;
        tick(80);
        chk("rand.count", 32'(got_n - rd), 32'(exp_q.size()));
        chk("rand.overrun", 32'(ovr_cnt - ov0), 0);
        foreach (exp_q[i]) begin
            if (rd < got_n) check_next($sformatf("rand%0d", i), exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
